bcd_mod_counter: RTL and testbench

//  Parametrised synchronous BCD modulo counter: NUM_DIGITS cascaded decades, wraps at MAX_VAL.

---
 rtl/bcd_cnt_pkg.sv | 32 +++
 rtl/bcd_mod_counter_digit.sv | 37 +++
 rtl/bcd_mod_counter.sv | 94 +++++++++
 tb/tb_bcd_mod_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared constants and elaboration-time helpers for the BCD modulo counter.
// Supports up to BCD_MAX_DIGITS decades, which keeps every BCD image within 32 bits.
package bcd_cnt_pkg;

  localparam int          BCD_DIGIT_W    = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;
  localparam int unsigned BCD_MAX_DIGITS = 8;

  function automatic logic [31:0] int_to_bcd(input int unsigned value, input int unsigned digits);
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[i*4 +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic bit max_val_ok(input int unsigned max_val, input int unsigned digits);
    int unsigned pow;
    pow = 1;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) pow = pow * 10;
    end
    return (digits >= 1) && (digits <= BCD_MAX_DIGITS) && (max_val >= 1) && (max_val < pow);
  endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// One BCD decade: parallel load, or +/-1 when enabled with carry/borrow in.
// Latency 1 cycle; co is combinational from q, up and ci.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ld_i,
  input  logic [BCD_DIGIT_W-1:0] ld_val_i,
  input  logic                   en_i,
  input  logic                   up_i,
  input  logic                   ci_i,
  output logic [BCD_DIGIT_W-1:0] q_o,
  output logic                   co_o
);

  logic [BCD_DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (en_i && ci_i) begin
      if (up_i) q_d = (q_q >= BCD_MAX_DIGIT) ? '0 : q_q + 4'd1;
      else      q_d = (q_q == '0) ? BCD_MAX_DIGIT : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o  = q_q;
  assign co_o = ci_i & (up_i ? (q_q == BCD_MAX_DIGIT) : (q_q == '0));

endmodule

// File: rtl/bcd_mod_counter.sv
// Cascadable BCD modulo counter (74160-style EP/ET/C) wrapping at MAX_VAL, up/down.
// Latency 1 cycle; C combinational, C_P and LD_ERR registered one-cycle pulses.
module bcd_mod_counter
  import bcd_cnt_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int MAX_VAL    = 59
) (
  input  logic                            CP,
  input  logic                            Rd,
  input  logic                            CLR,
  input  logic                            LD,
  input  logic                            EP,
  input  logic                            ET,
  input  logic                            UP,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] D,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] Q,
  output logic                            C,
  output logic                            C_P,
  output logic                            LD_ERR
);

  localparam int          W         = BCD_DIGIT_W * NUM_DIGITS;
  localparam logic [31:0] MAX_BCD32 = int_to_bcd(MAX_VAL, NUM_DIGITS);
  localparam logic [W-1:0] MAX_BCD  = MAX_BCD32[W-1:0];

  if (!max_val_ok(MAX_VAL, NUM_DIGITS)) begin : g_bad_params
    $error("bcd_mod_counter: MAX_VAL out of range for NUM_DIGITS");
  end

  logic            tc, cnt_en, wrap, nib_ok, d_valid, dig_ld;
  logic [W-1:0]    ld_val;
  logic [NUM_DIGITS:0] carry;
  logic            c_p_q, c_p_d, ld_err_q, ld_err_d;
  logic            unused_co;

  // Valid BCD nibbles order the same as binary, so a plain compare checks the range.
  always_comb begin
    nib_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (D[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) nib_ok = 1'b0;
    end
    d_valid = nib_ok && (D <= MAX_BCD);
  end

  assign tc     = UP ? (Q == MAX_BCD) : (Q == '0);
  assign cnt_en = EP & ET;
  assign wrap   = cnt_en & tc;
  assign dig_ld = ~CLR | ~LD | wrap;

  always_comb begin
    ld_val = '0;
    if (!CLR)     ld_val = '0;
    else if (!LD) ld_val = d_valid ? D : '0;
    else          ld_val = UP ? '0 : MAX_BCD;
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i    (CP),
      .rst_ni   (Rd),
      .ld_i     (dig_ld),
      .ld_val_i (ld_val[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .en_i     (cnt_en),
      .up_i     (UP),
      .ci_i     (carry[g]),
      .q_o      (Q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co_o     (carry[g+1])
    );
  end

  // The top digit's carry out is superseded by the MAX_VAL terminal compare.
  assign unused_co = carry[NUM_DIGITS];

  assign c_p_d    = wrap & CLR & LD;
  assign ld_err_d = CLR & ~LD & ~d_valid;

  always_ff @(posedge CP or negedge Rd) begin
    if (!Rd) begin
      c_p_q    <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      c_p_q    <= c_p_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign C      = ET & tc;
  assign C_P    = c_p_q;
  assign LD_ERR = ld_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: 00-59 main instance, 00-23, 000-999 and a cascaded mm:ss pair.
module tb_bcd_mod_counter;

  logic        cp = 1'b0;
  logic        rd_n, clr_n, ld_n, ep, et, up;
  logic [7:0]  d, d_h;
  logic [11:0] d_k;

  logic [7:0]  q, q_h, q_s, q_m;
  logic [11:0] q_k;
  logic        c, c_p, ld_err;
  logic        c_h, cp_h, le_h;
  logic        c_k, cp_k, le_k;
  logic        c_s, cp_s, le_s;
  logic        c_m, cp_m, le_m;

  int n_total = 0;
  int n_pass  = 0;

  always #5 cp = ~cp;

  bcd_mod_counter #(.NUM_DIGITS(2), .MAX_VAL(59)) u_dut (
    .CP(cp), .Rd(rd_n), .CLR(clr_n), .LD(ld_n), .EP(ep), .ET(et), .UP(up),
    .D(d), .Q(q), .C(c), .C_P(c_p), .LD_ERR(ld_err));

  bcd_mod_counter #(.NUM_DIGITS(2), .MAX_VAL(23)) u_hrs (
    .CP(cp), .Rd(rd_n), .CLR(clr_n), .LD(ld_n), .EP(ep), .ET(et), .UP(up),
    .D(d_h), .Q(q_h), .C(c_h), .C_P(cp_h), .LD_ERR(le_h));

  bcd_mod_counter #(.NUM_DIGITS(3), .MAX_VAL(999)) u_k (
    .CP(cp), .Rd(rd_n), .CLR(clr_n), .LD(ld_n), .EP(ep), .ET(et), .UP(up),
    .D(d_k), .Q(q_k), .C(c_k), .C_P(cp_k), .LD_ERR(le_k));

  bcd_mod_counter #(.NUM_DIGITS(2), .MAX_VAL(59)) u_sec (
    .CP(cp), .Rd(rd_n), .CLR(clr_n), .LD(ld_n), .EP(ep), .ET(et), .UP(up),
    .D(d), .Q(q_s), .C(c_s), .C_P(cp_s), .LD_ERR(le_s));

  bcd_mod_counter #(.NUM_DIGITS(2), .MAX_VAL(59)) u_min (
    .CP(cp), .Rd(rd_n), .CLR(clr_n), .LD(ld_n), .EP(ep), .ET(c_s), .UP(up),
    .D(d), .Q(q_m), .C(c_m), .C_P(cp_m), .LD_ERR(le_m));

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q;
    rd_n = 1'b0; clr_n = 1'b1; ld_n = 1'b1; ep = 1'b0; et = 1'b0; up = 1'b1;
    d = 8'h00; d_h = 8'h00; d_k = 12'h000;

    // Reset state
    #2;
    chk("rst_q", 12'(q), 12'h000);
    chk("rst_cp", 12'(c_p), 12'h000);
    chk("rst_lderr", 12'(ld_err), 12'h000);
    chk("rst_c_up", 12'(c), 12'h000);
    up = 1'b0; et = 1'b1; #1;
    chk("rst_c_dn", 12'(c), 12'h001);
    tick();
    rd_n = 1'b1; et = 1'b0; up = 1'b1;

    // 1. async reset mid-count, then digit carry 00..10
    d = 8'h37; ld_n = 1'b0; tick(); ld_n = 1'b1; #1;
    chk("ld37", 12'(q), 12'h037);
    rd_n = 1'b0; #1;
    chk("async_rst", 12'(q), 12'h000);
    rd_n = 1'b1; ep = 1'b1; et = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_q = (i == 10) ? 8'h10 : 8'(i);
      chk("count_up", 12'(q), 12'(exp_q));
    end

    // 2. up wrap at 59, ET hold
    d = 8'h58; ld_n = 1'b0; tick(); ld_n = 1'b1; #1;
    chk("q58", 12'(q), 12'h058);
    chk("c_at58", 12'(c), 12'h000);
    tick();
    chk("q59", 12'(q), 12'h059);
    chk("c_at59", 12'(c), 12'h001);
    chk("cp_pre_wrap", 12'(c_p), 12'h000);
    tick();
    chk("wrap_q00", 12'(q), 12'h000);
    chk("wrap_cp", 12'(c_p), 12'h001);
    tick();
    chk("q01", 12'(q), 12'h001);
    chk("cp_one_cycle", 12'(c_p), 12'h000);
    d = 8'h59; ld_n = 1'b0; tick(); ld_n = 1'b1; et = 1'b0; #1;
    chk("et0_c", 12'(c), 12'h000);
    tick();
    chk("et0_hold", 12'(q), 12'h059);
    chk("et0_no_cp", 12'(c_p), 12'h000);
    et = 1'b1; #1;
    chk("et1_c", 12'(c), 12'h001);

    // 3. down wrap and digit borrow
    up = 1'b0; d = 8'h01; ld_n = 1'b0; tick(); ld_n = 1'b1; #1;
    chk("dn_q01", 12'(q), 12'h001);
    chk("dn_c01", 12'(c), 12'h000);
    tick();
    chk("dn_q00", 12'(q), 12'h000);
    chk("dn_c00", 12'(c), 12'h001);
    up = 1'b1; #1;
    chk("up_flip_c", 12'(c), 12'h000);
    up = 1'b0; #1;
    chk("dn_flip_c", 12'(c), 12'h001);
    tick();
    chk("dn_wrap_q", 12'(q), 12'h059);
    chk("dn_wrap_cp", 12'(c_p), 12'h001);
    d = 8'h10; ld_n = 1'b0; tick(); ld_n = 1'b1;
    tick();
    chk("dn_borrow", 12'(q), 12'h009);

    // 4. load validation
    ep = 1'b0; ld_n = 1'b0; d = 8'h42; tick();
    chk("ld42_q", 12'(q), 12'h042);
    chk("ld42_err", 12'(ld_err), 12'h000);
    d = 8'h59; tick();
    chk("ld59_q", 12'(q), 12'h059);
    chk("ld59_err", 12'(ld_err), 12'h000);
    d = 8'h60; tick();
    chk("ld60_q", 12'(q), 12'h000);
    chk("ld60_err", 12'(ld_err), 12'h001);
    d = 8'h3A; tick();
    chk("ld3a_q", 12'(q), 12'h000);
    chk("ld3a_err", 12'(ld_err), 12'h001);
    ld_n = 1'b1; tick();
    chk("lderr_clear", 12'(ld_err), 12'h000);

    // 5. clear beats load and count
    d = 8'h59; ld_n = 1'b0; tick();
    ep = 1'b1; et = 1'b1; up = 1'b1; clr_n = 1'b0; d = 8'h42; #1;
    chk("clr_c_indep", 12'(c), 12'h001);
    tick();
    chk("clr_q", 12'(q), 12'h000);
    chk("clr_cp", 12'(c_p), 12'h000);
    chk("clr_lderr", 12'(ld_err), 12'h000);
    clr_n = 1'b1;

    // 6. other widths/moduli and cascade
    d = 8'h59; d_h = 8'h22; d_k = 12'h999; ld_n = 1'b0; tick(); ld_n = 1'b1; #1;
    chk("h_q22", 12'(q_h), 12'h022);
    chk("k_q999", q_k, 12'h999);
    chk("k_c", 12'(c_k), 12'h001);
    chk("m_c_cascade", 12'(c_m), 12'h001);
    tick();
    chk("h_q23", 12'(q_h), 12'h023);
    chk("h_c23", 12'(c_h), 12'h001);
    chk("k_wrap", q_k, 12'h000);
    chk("k_cp", 12'(cp_k), 12'h001);
    chk("s_wrap", 12'(q_s), 12'h000);
    chk("m_wrap", 12'(q_m), 12'h000);
    chk("m_cp", 12'(cp_m), 12'h001);
    tick();
    chk("h_wrap", 12'(q_h), 12'h000);
    chk("h_cp", 12'(cp_h), 12'h001);
    chk("m_hold", 12'(q_m), 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
